// File: rtl/brg_pkg.sv
// Shared constants and types for the parametrised baud-rate generator.
// Optional fractional divisor is enabled by defining BRG_FRAC_EN.
package brg_pkg;

  localparam logic [1:0] ADDR_DB_LO = 2'b10;
  localparam logic [1:0] ADDR_DB_HI = 2'b11;

  localparam int FRAC_W = 4;

  typedef enum logic {
    UNCFG = 1'b0,
    RUN   = 1'b1
  } brg_state_e;

  typedef struct packed {
    logic wr_lo;
    logic commit;
    logic resync;
  } brg_ctl_t;

endpackage

// File: rtl/brg_phase_ctr.sv
// OSR-modulo bit-phase down counter with load and decrement enable.
// Flags the bit boundary (phase 0) and the mid-bit sample point (OSR/2).
module brg_phase_ctr #(
  parameter int OSR = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic at_zero,
  output logic at_mid
);

  localparam int PH_W = $clog2(OSR);
  localparam logic [PH_W-1:0] PH_TOP = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0] PH_MID = PH_W'(OSR / 2);

  logic [PH_W-1:0] phase_q;

  // OSR is a power of two, so plain underflow wraps 0 to OSR-1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= PH_TOP;
    end else if (load) begin
      phase_q <= PH_TOP;
    end else if (dec) begin
      phase_q <= phase_q - 1'b1;
    end
  end

  assign at_zero = (phase_q == '0);
  assign at_mid  = (phase_q == PH_MID);

endmodule

// File: rtl/brg_param.sv
// Parametrised UART baud-rate generator: oversample tick, tx bit enable,
// rx mid-bit enable. Define BRG_FRAC_EN to add the div_frac fraction input.
module brg_param
  import brg_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int OSR   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              iowr,
  input  logic [1:0]        ioaddr,
  input  logic [7:0]        data,
`ifdef BRG_FRAC_EN
  input  logic [FRAC_W-1:0] div_frac,
`endif
  input  logic              rx_resync,
  output logic              os_tick,
  output logic              baud_trmt_en,
  output logic              baud_receive_en,
  output logic              cfg_valid
);

`ifdef BRG_FRAC_EN
  localparam int CNT_W = DIV_W + 1;
`else
  localparam int CNT_W = DIV_W;
`endif

  brg_state_e       state_q;
  brg_state_e       state_d;
  brg_ctl_t         ctl;
  logic [7:0]       shadow_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_new;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] reload;
  logic             run;
  logic             ph_zero;
  logic             ph_mid;
  logic             ph_load;
  logic             ph_dec;

  assign run = (state_q == RUN);

  always_comb begin
    ctl        = '0;
    ctl.wr_lo  = iowr && (ioaddr == ADDR_DB_LO);
    ctl.commit = iowr && (ioaddr == ADDR_DB_HI);
    ctl.resync = run && rx_resync;
  end

  assign div_new = {data[DIV_W-9:0], shadow_q};

  always_comb begin
    state_d = state_q;
    if (ctl.commit) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= UNCFG;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
      div_q    <= '0;
    end else begin
      if (ctl.wr_lo) begin
        shadow_q <= data;
      end
      if (ctl.commit) begin
        div_q <= div_new;
      end
    end
  end

`ifdef BRG_FRAC_EN
  logic [FRAC_W-1:0] frac_q;
  logic [FRAC_W-1:0] acc_q;
  logic [FRAC_W:0]   acc_sum;

  // carry out of the fraction accumulator stretches this period by one
  assign acc_sum = {1'b0, acc_q} + {1'b0, frac_q};
  assign reload  = {1'b0, div_q} + CNT_W'(acc_sum[FRAC_W]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frac_q <= '0;
      acc_q  <= '0;
    end else if (ctl.commit) begin
      frac_q <= div_frac;
      acc_q  <= '0;
    end else if (ctl.resync) begin
      acc_q  <= '0;
    end else if (os_tick) begin
      acc_q  <= acc_sum[FRAC_W-1:0];
    end
  end
`else
  assign reload = div_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '1;
    end else if (ctl.commit) begin
      cnt_q <= CNT_W'(div_new);
    end else if (ctl.resync) begin
      cnt_q <= CNT_W'(div_q);
    end else if (run && en) begin
      cnt_q <= (cnt_q == '0) ? reload : cnt_q - 1'b1;
    end
  end

  assign ph_load = ctl.commit || ctl.resync;
  assign ph_dec  = os_tick && !ph_load;

  brg_phase_ctr #(
    .OSR(OSR)
  ) u_phase (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (ph_load),
    .dec    (ph_dec),
    .at_zero(ph_zero),
    .at_mid (ph_mid)
  );

  assign os_tick         = run && en && (cnt_q == '0);
  assign baud_trmt_en    = os_tick && ph_zero;
  assign baud_receive_en = os_tick && ph_mid;
  assign cfg_valid       = run;

endmodule

// File: tb/tb_brg_param.sv
// Directed self-checking bench for brg_param (DIV_W=16, OSR=16).
// Fraction checks run only when BRG_FRAC_EN is defined.
module tb_brg_param;
  import brg_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       iowr;
  logic [1:0] ioaddr;
  logic [7:0] data;
  logic       rx_resync;
  logic       os_tick;
  logic       baud_trmt_en;
  logic       baud_receive_en;
  logic       cfg_valid;
`ifdef BRG_FRAC_EN
  logic [FRAC_W-1:0] div_frac;
`endif

  int errors = 0;
  int checks = 0;
  int osq[$];
  int trq[$];
  int rxq[$];
  int both;
  int garbage;

  brg_param #(
    .DIV_W(16),
    .OSR  (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .iowr           (iowr),
    .ioaddr         (ioaddr),
    .data           (data),
`ifdef BRG_FRAC_EN
    .div_frac       (div_frac),
`endif
    .rx_resync      (rx_resync),
    .os_tick        (os_tick),
    .baud_trmt_en   (baud_trmt_en),
    .baud_receive_en(baud_receive_en),
    .cfg_valid      (cfg_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    iowr   = 1'b1;
    ioaddr = a;
    data   = d;
    step();
    iowr   = 1'b0;
  endtask

  // sample n cycles; offsets are relative to the first sampled cycle
  task automatic watch(input int n);
    osq.delete();
    trq.delete();
    rxq.delete();
    both    = 0;
    garbage = 0;
    for (int k = 0; k < n; k++) begin
      if (os_tick === 1'b1) osq.push_back(k);
      if (baud_trmt_en === 1'b1) trq.push_back(k);
      if (baud_receive_en === 1'b1) rxq.push_back(k);
      if (baud_trmt_en === 1'b1 && baud_receive_en === 1'b1) both++;
      if ($isunknown({os_tick, baud_trmt_en, baud_receive_en})) garbage++;
      step();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    iowr      = 1'b0;
    ioaddr    = 2'b00;
    data      = 8'h00;
    rx_resync = 1'b0;
`ifdef BRG_FRAC_EN
    div_frac  = '0;
`endif
    step();
    step();
    chk("rst_cfg", int'(cfg_valid), 0);
    chk("rst_os", int'(os_tick), 0);
    chk("rst_trmt", int'(baud_trmt_en), 0);
    chk("rst_recv", int'(baud_receive_en), 0);

    rst_n = 1'b1;
    watch(200);
    chk("uncfg_os", osq.size(), 0);
    chk("uncfg_tr", trq.size() + rxq.size(), 0);
    chk("uncfg_cfg", int'(cfg_valid), 0);
    chk("uncfg_x", garbage, 0);

    // divisor 3: os every 4, trmt every 64, recv 32 after commit-phase
    wr(ADDR_DB_LO, 8'h03);
    chk("lo_only_cfg", int'(cfg_valid), 0);
    wr(ADDR_DB_HI, 8'h00);
    chk("commit_cfg", int'(cfg_valid), 1);
    watch(128);
    chk("d3_first_os", at(osq, 0), 3);
    chk("d3_os_per", at(osq, 1) - at(osq, 0), 4);
    chk("d3_os_cnt", osq.size(), 32);
    chk("d3_first_rx", at(rxq, 0), 31);
    chk("d3_first_tr", at(trq, 0), 63);
    chk("d3_tr_per", at(trq, 1) - at(trq, 0), 64);
    chk("d3_rx_tr_off", at(trq, 0) - at(rxq, 0), 32);
    chk("d3_excl", both, 0);

    // low byte alone must not change the running period
    wr(ADDR_DB_LO, 8'h07);
    watch(20);
    chk("lo7_first_os", at(osq, 0), 2);
    chk("lo7_per", at(osq, 1) - at(osq, 0), 4);

    wr(ADDR_DB_HI, 8'h00);
    watch(70);
    chk("d7_first_os", at(osq, 0), 7);
    chk("d7_per", at(osq, 1) - at(osq, 0), 8);
    chk("d7_first_rx", at(rxq, 0), 63);
    chk("d7_no_tr", trq.size(), 0);

    // rx resync: recv at pulse+32, trmt at pulse+64
    wr(ADDR_DB_LO, 8'h03);
    wr(ADDR_DB_HI, 8'h00);
    watch(10);
    rx_resync = 1'b1;
    step();
    rx_resync = 1'b0;
    watch(70);
    chk("rs_first_os", at(osq, 0), 3);
    chk("rs_first_rx", at(rxq, 0) + 1, 32);
    chk("rs_first_tr", at(trq, 0) + 1, 64);
    chk("rs_excl", both, 0);

    // commit and resync together: committed divisor (1) wins
    wr(ADDR_DB_LO, 8'h01);
    iowr      = 1'b1;
    ioaddr    = ADDR_DB_HI;
    data      = 8'h00;
    rx_resync = 1'b1;
    step();
    iowr      = 1'b0;
    rx_resync = 1'b0;
    watch(10);
    chk("cr_first_os", at(osq, 0), 1);
    chk("cr_per", at(osq, 1) - at(osq, 0), 2);

    // en drop for 10 cycles delays the next tick by exactly 10
    wr(ADDR_DB_LO, 8'h03);
    wr(ADDR_DB_HI, 8'h00);
    watch(10);
    chk("pre_drop_os", osq.size(), 2);
    en = 1'b0;
    watch(10);
    chk("drop_os", osq.size(), 0);
    chk("drop_tr", trq.size() + rxq.size(), 0);
    en = 1'b1;
    watch(10);
    chk("resume_os", at(osq, 0), 1);
    chk("resume_per", at(osq, 1) - at(osq, 0), 4);

    // reset mid-run returns to unconfigured
    rst_n = 1'b0;
    step();
    chk("mrst_cfg", int'(cfg_valid), 0);
    chk("mrst_os", int'(os_tick), 0);
    rst_n = 1'b1;
    watch(50);
    chk("mrst_idle", osq.size(), 0);

    // writes accepted with en low; counting waits for en
    en = 1'b0;
    wr(ADDR_DB_LO, 8'h03);
    wr(ADDR_DB_HI, 8'h00);
    chk("en0_cfg", int'(cfg_valid), 1);
    watch(8);
    chk("en0_os", osq.size(), 0);
    en = 1'b1;
    watch(8);
    chk("en1_first_os", at(osq, 0), 3);

`ifdef BRG_FRAC_EN
    // divisor 3, frac 8: periods 4,5,4,5..., 16 periods = 72 cycles
    div_frac = 4'd8;
    wr(ADDR_DB_LO, 8'h03);
    wr(ADDR_DB_HI, 8'h00);
    div_frac = 4'd0;
    watch(100);
    chk("fr_first_os", at(osq, 0), 3);
    chk("fr_per0", at(osq, 1) - at(osq, 0), 4);
    chk("fr_per1", at(osq, 2) - at(osq, 1), 5);
    chk("fr_16per", at(osq, 16) - at(osq, 0), 72);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/brg_param.md
Name: brg_param

Overview:
- Parametrised successor to the UART baud-rate generator. Produces an oversample tick, a transmit-bit enable and a mid-bit receive enable from a divisor programmed over the 8-bit I/O bus.
- Adds over the previous generation:
  - explicit write strobe
  - divisor width and oversample-ratio parameters
  - run enable
  - receive-phase resync on start-bit detect
  - a configured flag
- Sits between the bus interface decoder and the UART tx/rx engines.

Parameters:
- DIV_W, 16, active divisor width; legal range 9..16; high-byte bits above DIV_W-8 are ignored.
- OSR, 16, oversample ticks per bit; power of two, ≥4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  run enable; low freezes counters and suppresses all ticks
- iowr  in  1  bus write strobe, one cycle
- ioaddr  in  2  bus address; 2'b10 = divisor low byte, 2'b11 = divisor high byte
- data  in  8  bus write data
- rx_resync  in  1  one-cycle pulse from rx start-bit detect
- os_tick  out  1  oversample tick
- baud_trmt_en  out  1  tx bit-boundary pulse
- baud_receive_en  out  1  rx mid-bit sample pulse
- cfg_valid  out  1  high once a divisor has been committed

Behaviour:
- Reset (synchronous, rst_n low at posedge clk):
  - shadow and active divisor = 0
  - down counter = all ones
  - phase counter = OSR-1
  - cfg_valid = 0
  - all tick outputs 0
- Bus writes (effective only when iowr=1):
  - Low-byte write loads shadow[7:0] only.
  - High-byte write commits {data[DIV_W-9:0], shadow[7:0]} to the active divisor and sets cfg_valid.
  - Other addresses are ignored. Writes are accepted regardless of en.
- States: UNCFG (cfg_valid=0), RUN.
  - UNCFG→RUN on the first commit.
  - RUN→RUN on any later commit.
  - Only reset returns to UNCFG.
  - In UNCFG, counters hold their reset values and no ticks are issued.
- Commit: on the cycle after the high-byte write, down counter = new divisor and phase = OSR-1. The commit also restarts the bit phase.
- Counting in RUN with en=1:
  - Down counter decrements each cycle.
  - When it equals 0: os_tick=1, counter reloads the active divisor, phase decrements with wrap from 0 to OSR-1.
  - os_tick period is divisor+1 cycles; divisor 0 gives os_tick every cycle.
- Tick outputs are combinational from registered state:
  - baud_trmt_en = os_tick & (phase==0)
  - baud_receive_en = os_tick & (phase==OSR/2)
  - baud_trmt_en and baud_receive_en are never high together.
- rx_resync:
  - Next cycle, counter = active divisor and phase = OSR-1.
  - First baud_receive_en lands (OSR/2)·(div+1) cycles after the pulse cycle; baud_trmt_en lands OSR·(div+1) cycles after it.
  - Ignored in UNCFG.
- en low: counter and phase hold and outputs are 0. Counting resumes from the held values when en rises.
- Priority, same cycle: reset > commit > rx_resync > en low > count.
- Reset mid-bit: all state returns to reset values immediately; the divisor must be reprogrammed.

Optional Feature:
- Macro BRG_FRAC_EN.
- Defined:
  - Adds input port div_frac[3:0], sampled at commit into an active fraction register.
  - A 4-bit accumulator adds the fraction at every reload. On carry-out, that reload loads divisor+1, stretching that os period by one cycle.
  - Average os period = div+1+frac/16.
  - Accumulator clears on reset, commit and rx_resync.
- Not defined: port and accumulator are absent and behaviour is exactly as above.

Decomposition:
- brg_pkg holds:
  - ADDR_DB_LO = 2'b10
  - ADDR_DB_HI = 2'b11
  - state enum {UNCFG, RUN}
  - FRAC_W = 4
- One sub-module, brg_phase_ctr: OSR-modulo down counter with load, decrement-enable and phase-compare outputs. The divisor logic stays in the top.

Test Plan:
- Reset, then en=1 with no writes for 200 cycles → cfg_valid=0 and no ticks.
- DIV_W=16, OSR=16. Write lo=0x03 then hi=0x00 → os_tick every 4 cycles, baud_trmt_en every 64 cycles, baud_receive_en 32 cycles offset from trmt.
- Mid-run, write lo=0x07 only → period unchanged. Then write hi=0x00 → next-cycle restart, os period becomes 8.
- With divisor 3, pulse rx_resync at cycle T → baud_receive_en at T+32 and baud_trmt_en at T+64. Also pulse rx_resync on the same cycle as a hi write → commit value wins.
- Drop en for 10 cycles mid-bit → no ticks during the drop, and the next tick is delayed by exactly 10 cycles.
- BRG_FRAC_EN with divisor 3 and frac 8 → os periods alternate 4,5; 16 periods total 72 cycles. Without the macro, confirm the div_frac port is absent.
